wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning writeback data width.
REQ-002 SHALL have parameter REG_W, default 5, meaning register index width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning ordered queue entries (power of two, >=2).
REQ-004 SHALL have one clock and an asynchronous active-low reset, named and ordered as follows.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have per-lane inputs, for lane k in {0,1}:
- ink_valid  input  1  lane k result present.
- ink_aluout  input  DATA_W  ALU result.
- ink_read_data  input  DATA_W  load data.
- ink_mem_to_reg  input  1  1 selects read_data, 0 selects aluout.
- ink_rd  input  REG_W  destination register.
- ink_reg_write  input  1  result writes the register file.
REQ-006 SHALL have in_ready  output  1  both lanes may present this cycle.
REQ-007 SHALL have the single register-file write port:
- wb_valid  output  1  wb_rd/wb_data valid.
- wb_ready  input  1  register file accepts this cycle.
- wb_rd  output  REG_W  write index.
- wb_data  output  DATA_W  write data.
REQ-008 SHALL have count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-009 SHALL select data per lane before enqueue: mem_to_reg ? read_data : aluout.
REQ-010 SHALL drive in_ready=1 iff free slots (DEPTH-count) >= 2, registered-state based with no combinational path from inputs.
REQ-011 SHALL accept lane k on a rising edge with ink_valid && in_ready; ink_valid while in_ready=0 SHALL be ignored, and the sender holds it.
REQ-012 SHALL drop an accepted lane with reg_write=0 or rd=0 without enqueueing it.
REQ-013 SHALL enqueue lane0 ahead of lane1 when both are enqueued in the same cycle, so register-file write order equals program order.
REQ-014 SHALL drive wb_valid=(count!=0) and wb_rd/wb_data from the queue head, combinationally from registered state.
REQ-015 SHALL pop the head on a rising edge with wb_valid && wb_ready; outputs SHALL stay stable while wb_valid && !wb_ready.
REQ-016 SHALL allow simultaneous pop and push(es) in one cycle: count_next = count + pushes - pop.
REQ-017 SHALL give zero-cycle latency from enqueue to visibility: an entry enqueued at edge N is at wb_* after edge N if the queue was empty.
REQ-018 SHALL wrap read/write pointers modulo DEPTH, with full/empty distinguished by count only.
REQ-019 SHALL never overflow, since in_ready guarantees 2 free slots, and SHALL never pop when empty.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear pointers and count to 0 and force wb_valid=0 and in_ready=1; wb_rd/wb_data SHALL be 0.
REQ-021 SHALL discard queued entries if reset asserts mid-operation, with no partial write issued after release.

Configuration
REQ-022 SHALL, with WB_SQUASH_EN defined, drop lane0 when both lanes would enqueue in the same cycle with equal rd, leaving only lane1 enqueued (lane0's value is dead); count SHALL increase by 1.
REQ-023 SHALL, without WB_SQUASH_EN, enqueue both entries in order per REQ-013.

Verification
REQ-024 SHALL verify that after reset, count=0, wb_valid=0 and in_ready=1.
REQ-025 SHALL verify: in0 {aluout=12345678, mem_to_reg=0, rd=3} and in1 {read_data=87654321, mem_to_reg=1, rd=4}, wb_ready=1 -> wb writes (3,12345678) then (4,87654321) on consecutive cycles.
REQ-026 SHALL verify: in0 rd=0 and in1 reg_write=0, both valid -> count stays 0 and no wb_valid.
REQ-027 SHALL verify: wb_ready=0 while 2 pairs are pushed -> count=4, in_ready=0, and a third pair is ignored; then wb_ready=1 -> 4 writes in order, with in_ready=1 once count<=2.
REQ-028 SHALL verify: both lanes rd=7, data AABBCCDD/DEADBEEF -> with WB_SQUASH_EN, a single write (7,DEADBEEF); without it, (7,AABBCCDD) then (7,DEADBEEF).
REQ-029 SHALL verify: rst_n pulled low with count=3 -> wb_valid=0 immediately, and after release no stale write occurs.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges two writeback lanes into the single register-file write
// port through an ordered queue. Lane 0 is always queued ahead of lane 1, so
// the register file sees writes in program order.
// Optional build macro: WB_SQUASH_EN. When it is defined and both lanes enqueue
// to the same rd in one cycle, lane 0 is dropped because its value is dead.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       in0_valid,
    input  logic [DATA_W-1:0]          in0_aluout,
    input  logic [DATA_W-1:0]          in0_read_data,
    input  logic                       in0_mem_to_reg,
    input  logic [REG_W-1:0]           in0_rd,
    input  logic                       in0_reg_write,

    input  logic                       in1_valid,
    input  logic [DATA_W-1:0]          in1_aluout,
    input  logic [DATA_W-1:0]          in1_read_data,
    input  logic                       in1_mem_to_reg,
    input  logic [REG_W-1:0]           in1_rd,
    input  logic                       in1_reg_write,

    output logic                       in_ready,

    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [REG_W-1:0]           wb_rd,
    output logic [DATA_W-1:0]          wb_data,

    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Highest occupancy that still leaves room for a full lane pair.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    // Result mux: loads write the memory data, everything else the ALU result.
    function automatic logic [DATA_W-1:0] sel_data(
        input logic                mem_to_reg,
        input logic [DATA_W-1:0]   read_data,
        input logic [DATA_W-1:0]   aluout
    );
        return mem_to_reg ? read_data : aluout;
    endfunction

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              push0;
    logic              push1;
    logic              pop;
    logic [PTR_W-1:0]  wr_idx1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;

    // Flow control is a pure function of occupancy, so no input reaches it.
    assign in_ready = (count <= READY_MAX);
    assign wb_valid = (count != '0);
    // The head slot is not reset; gate it so an empty queue shows zeros.
    assign wb_rd    = wb_valid ? rd_q[rd_ptr]   : '0;
    assign wb_data  = wb_valid ? data_q[rd_ptr] : '0;

    assign data0 = sel_data(in0_mem_to_reg, in0_read_data, in0_aluout);
    assign data1 = sel_data(in1_mem_to_reg, in1_read_data, in1_aluout);

    // Decide which accepted lanes actually need a register-file write.
    always_comb begin
        push0 = in0_valid && in_ready && in0_reg_write && (in0_rd != '0);
        push1 = in1_valid && in_ready && in1_reg_write && (in1_rd != '0);
`ifdef WB_SQUASH_EN
        if (push0 && push1 && (in0_rd == in1_rd)) begin
            push0 = 1'b0;
        end
`endif
        pop     = wb_valid && wb_ready;
        // Lane 1 lands right behind lane 0 when both are queued together.
        wr_idx1 = wr_ptr + PTR_W'(push0);
    end

    // Queue control: pointers wrap naturally, occupancy tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    // Queue storage: written in program order, never needs clearing.
    always_ff @(posedge clk) begin
        if (push0) begin
            data_q[wr_ptr] <= data0;
            rd_q[wr_ptr]   <= in0_rd;
        end
        if (push1) begin
            data_q[wr_idx1] <= data1;
            rd_q[wr_idx1]   <= in1_rd;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of the two-lane writeback arbiter.
// Build with WB_SQUASH_EN defined to check the same-rd squash behaviour.
module tb_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              in0_valid, in1_valid;
    logic [DATA_W-1:0] in0_aluout, in0_read_data, in1_aluout, in1_read_data;
    logic              in0_mem_to_reg, in1_mem_to_reg;
    logic [REG_W-1:0]  in0_rd, in1_rd;
    logic              in0_reg_write, in1_reg_write;
    logic              in_ready;
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in0_valid      (in0_valid),
        .in0_aluout     (in0_aluout),
        .in0_read_data  (in0_read_data),
        .in0_mem_to_reg (in0_mem_to_reg),
        .in0_rd         (in0_rd),
        .in0_reg_write  (in0_reg_write),
        .in1_valid      (in1_valid),
        .in1_aluout     (in1_aluout),
        .in1_read_data  (in1_read_data),
        .in1_mem_to_reg (in1_mem_to_reg),
        .in1_rd         (in1_rd),
        .in1_reg_write  (in1_reg_write),
        .in_ready       (in_ready),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane0(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic m2r, input logic [4:0] rd, input logic rw);
        in0_valid = v; in0_aluout = alu; in0_read_data = rdat;
        in0_mem_to_reg = m2r; in0_rd = rd; in0_reg_write = rw;
    endtask

    task automatic lane1(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic m2r, input logic [4:0] rd, input logic rw);
        in1_valid = v; in1_aluout = alu; in1_read_data = rdat;
        in1_mem_to_reg = m2r; in1_rd = rd; in1_reg_write = rw;
    endtask

    task automatic idle();
        lane0(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        lane1(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic head(input string tag, input logic [4:0] rd, input logic [31:0] data,
                        input int cnt);
        check({tag, ".valid"}, wb_valid, 1);
        check({tag, ".rd"}, wb_rd, rd);
        check({tag, ".data"}, wb_data, data);
        check({tag, ".count"}, count, cnt);
    endtask

    task automatic empty(input string tag);
        check({tag, ".valid"}, wb_valid, 0);
        check({tag, ".count"}, count, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        wb_ready = 1'b0;
        idle();
        #12;
        // Reset state
        check("rst.count", count, 0);
        check("rst.valid", wb_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.rd", wb_rd, 0);
        check("rst.data", wb_data, 0);
        step();
        rst_n = 1'b1;
        step();

        // Lane mux and program order, drained back to back
        lane0(1'b1, 32'h12345678, 32'hFFFF0000, 1'b0, 5'd3, 1'b1);
        lane1(1'b1, 32'h0000FFFF, 32'h87654321, 1'b1, 5'd4, 1'b1);
        wb_ready = 1'b1;
        step();
        idle();
        head("order.w0", 5'd3, 32'h12345678, 2);
        step();
        head("order.w1", 5'd4, 32'h87654321, 1);
        step();
        empty("order.done");

        // rd=0 and reg_write=0 are dropped
        lane0(1'b1, 32'h11111111, 32'h0, 1'b0, 5'd0, 1'b1);
        lane1(1'b1, 32'h22222222, 32'h0, 1'b0, 5'd5, 1'b0);
        step();
        idle();
        empty("drop");
        step();
        empty("drop.after");

        // Fill to full with the port stalled; a third pair is ignored
        wb_ready = 1'b0;
        lane0(1'b1, 32'h11, 32'h0, 1'b0, 5'd1, 1'b1);
        lane1(1'b1, 32'h22, 32'h0, 1'b0, 5'd2, 1'b1);
        step();
        check("fill1.count", count, 2);
        check("fill1.in_ready", in_ready, 1);
        lane0(1'b1, 32'h33, 32'h0, 1'b0, 5'd3, 1'b1);
        lane1(1'b1, 32'h44, 32'h0, 1'b0, 5'd4, 1'b1);
        step();
        check("fill2.count", count, 4);
        check("fill2.in_ready", in_ready, 0);
        lane0(1'b1, 32'h55, 32'h0, 1'b0, 5'd5, 1'b1);
        lane1(1'b1, 32'h66, 32'h0, 1'b0, 5'd6, 1'b1);
        step();
        head("full.hold", 5'd1, 32'h11, 4);
        check("full.in_ready", in_ready, 0);
        idle();
        wb_ready = 1'b1;
        step();
        head("drain.w1", 5'd2, 32'h22, 3);
        check("drain.w1.in_ready", in_ready, 0);
        step();
        head("drain.w2", 5'd3, 32'h33, 2);
        check("drain.w2.in_ready", in_ready, 1);
        step();
        head("drain.w3", 5'd4, 32'h44, 1);
        step();
        empty("drain.done");

        // Push a pair while popping in the same cycle
        lane0(1'b1, 32'h1B, 32'h0, 1'b0, 5'd11, 1'b1);
        lane1(1'b1, 32'h1C, 32'h0, 1'b0, 5'd12, 1'b1);
        step();
        head("pp.a", 5'd11, 32'h1B, 2);
        lane0(1'b1, 32'h0, 32'h1D, 1'b1, 5'd13, 1'b1);
        lane1(1'b1, 32'h1E, 32'h0, 1'b0, 5'd14, 1'b1);
        step();
        idle();
        head("pp.b", 5'd12, 32'h1C, 3);
        step();
        head("pp.c", 5'd13, 32'h1D, 2);
        step();
        head("pp.d", 5'd14, 32'h1E, 1);
        step();
        empty("pp.done");

        // Same destination on both lanes
        lane0(1'b1, 32'hAABBCCDD, 32'h0, 1'b0, 5'd7, 1'b1);
        lane1(1'b1, 32'h0, 32'hDEADBEEF, 1'b1, 5'd7, 1'b1);
        step();
        idle();
`ifdef WB_SQUASH_EN
        head("squash.w", 5'd7, 32'hDEADBEEF, 1);
        step();
        empty("squash.done");
`else
        head("same.w0", 5'd7, 32'hAABBCCDD, 2);
        step();
        head("same.w1", 5'd7, 32'hDEADBEEF, 1);
        step();
        empty("same.done");
`endif

        // Reset mid-operation with three entries queued
        wb_ready = 1'b0;
        lane0(1'b1, 32'h08, 32'h0, 1'b0, 5'd8, 1'b1);
        lane1(1'b1, 32'h09, 32'h0, 1'b0, 5'd9, 1'b1);
        step();
        lane0(1'b1, 32'h0A, 32'h0, 1'b0, 5'd10, 1'b1);
        lane1(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        step();
        idle();
        head("prerst", 5'd8, 32'h08, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", wb_valid, 0);
        check("arst.count", count, 0);
        check("arst.data", wb_data, 0);
        check("arst.in_ready", in_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            empty("postrst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
